aes_inv_round_sequencer: RTL and testbench

// - Iterative AES decryption: one inverse round per clock through one shared round datapath instead of nr unrolled rounds.
// - Sits between the block source (valid/ready) and the plaintext sink; the expanded key schedule comes from the key-expansion block.
// - Owns the round counter, round-key word selection, handshakes and result holding.

---
 rtl/aes_inv_round_sequencer_pkg.sv | 40 ++++
 rtl/aes_inv_round_sequencer_round.sv | 27 ++
 rtl/aes_inv_round_sequencer.sv | 87 ++++++++
 tb/tb_aes_inv_round_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_round_sequencer_pkg.sv
// aes_inv_round_sequencer_pkg: GF(2^8) arithmetic, inverse S-box and InvMixColumns constants
// shared by the iterative AES decryption datapath.
package aes_inv_round_sequencer_pkg;

    // InvMixColumns circulant row, IMC_COEF[k] multiplies the byte k places below the output row
    localparam logic [3:0][7:0] IMC_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    function automatic logic [7:0] mult(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sq(input logic [7:0] a);
        return mult(a, a);
    endfunction

    // multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a3;
        logic [7:0] a12;
        logic [7:0] a240;
        a3 = mult(sq(a), a);
        a12 = sq(sq(a3));
        a240 = sq(sq(sq(sq(mult(a12, a3)))));
        return mult(mult(a240, a12), sq(a));
    endfunction

    // inverse affine transform followed by field inversion
    function automatic logic [7:0] invsubbytef(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round_sequencer_round.sv
// aes_inv_round: one combinational AES inverse round; InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_inv_round_sequencer_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rkey,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0] ak [16];

    // byte 4*c+r is row r of column c; row r is rotated right by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_key
            assign ak[4*c+r] = invsubbytef(state_in[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ rkey[127-8*(4*c+r) -: 8];
        end
        for (genvar r = 0; r < 4; r++) begin : g_mix
            logic [7:0] m;
            assign m = mult(IMC_COEF[(4-r)%4], ak[4*c])   ^ mult(IMC_COEF[(5-r)%4], ak[4*c+1]) ^
                       mult(IMC_COEF[(6-r)%4], ak[4*c+2]) ^ mult(IMC_COEF[(7-r)%4], ak[4*c+3]);
            assign state_out[127-8*(4*c+r) -: 8] = last ? ak[4*c+r] : m;
        end
    end

endmodule

// File: rtl/aes_inv_round_sequencer.sv
// aes_inv_round_sequencer: iterative AES decryption, one inverse round per clock through a single
// shared round datapath, with valid/ready handshakes on both sides.
module aes_inv_round_sequencer
    import aes_inv_round_sequencer_pkg::*;
#(
    parameter int nk = 8,
    parameter int nb = 4,
    parameter int nr = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*nb-1:0]        in_cipher,
    input  logic [32*nb*(nr+1)-1:0] w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*nb-1:0]        out_msg,
    output logic                    busy,
    output logic [3:0]              round_idx
);

    if (nb != 4 || !((nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14))) begin : g_bad_params
        $error("aes_inv_round_sequencer: unsupported (nk, nb, nr) combination");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_idx_q, round_idx_d;
    logic [127:0] rkey_words, rkey, round_out;

    // schedule word 4*i is the leftmost (top) column of round key i
    assign rkey_words = w[128*round_idx_q +: 128];
    assign rkey = {rkey_words[31:0], rkey_words[63:32], rkey_words[95:64], rkey_words[127:96]};

    aes_inv_round u_round (
        .state_in (state_q),
        .rkey     (rkey),
        .last     (round_idx_q == 4'd0),
        .state_out(round_out)
    );

    always_comb begin
        fsm_d = fsm_q;
        state_d = state_q;
        round_idx_d = round_idx_q;
        case (fsm_q)
            IDLE: begin
                fsm_d = in_valid ? LOAD : IDLE;
                state_d = in_valid ? in_cipher : state_q;
                round_idx_d = in_valid ? 4'(nr) : round_idx_q;
            end
            LOAD: begin
                fsm_d = RUN;
                state_d = state_q ^ rkey;
                round_idx_d = 4'(nr - 1);
            end
            RUN: begin
                fsm_d = (round_idx_q == 4'd0) ? DONE : RUN;
                state_d = round_out;
                round_idx_d = (round_idx_q == 4'd0) ? 4'd0 : round_idx_q - 4'd1;
            end
            default: fsm_d = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            state_q <= '0;
            round_idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            state_q <= state_d;
            round_idx_q <= round_idx_d;
        end
    end

    assign in_ready = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy = (fsm_q == LOAD) || (fsm_q == RUN);
    assign out_msg = state_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_aes_inv_round_sequencer.sv
// tb_aes_inv_round_sequencer: AES-128/192/256 instances checked against FIPS-197 vectors and an
// independent forward-cipher model via a scoreboard; covers backpressure, back-to-back, reset and random traffic.
module tb_aes_inv_round_sequencer;

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    typedef struct {
        int           d;
        logic [127:0] pt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] in_valid;
    logic [2:0] out_ready;
    logic [127:0] in_cipher [3];
    logic [1407:0] w128;
    logic [1663:0] w192;
    logic [1919:0] w256;
    logic [1919:0] w_hold;
    wire [2:0] in_ready, out_valid, busy;
    wire [127:0] out_msg [3];
    wire [3:0] round_idx [3];

    logic [7:0] sbox [256];
    logic [31:0] kw [60];
    vec_t vecs [3];
    exp_t sb_q [$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_k [3];
    logic [2:0] ov_prev = '0;

    aes_inv_round_sequencer #(.nk(4), .nb(4), .nr(10)) dut128 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_cipher(in_cipher[0]),
        .w(w128), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_msg(out_msg[0]),
        .busy(busy[0]), .round_idx(round_idx[0]));
    aes_inv_round_sequencer #(.nk(6), .nb(4), .nr(12)) dut192 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_cipher(in_cipher[1]),
        .w(w192), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_msg(out_msg[1]),
        .busy(busy[1]), .round_idx(round_idx[1]));
    aes_inv_round_sequencer #(.nk(8), .nb(4), .nr(14)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_cipher(in_cipher[2]),
        .w(w256), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_msg(out_msg[2]),
        .busy(busy[2]), .round_idx(round_idx[2]));

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic int nk_of(input int d);
        return 4 + 2 * d;
    endfunction

    function automatic int nr_of(input int d);
        return 10 + 2 * d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---- reference model: forward cipher built from first principles ----
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 7; i >= 0; i--) p = xt(p) ^ (b[i] ? a : 8'h00);
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v;
            v = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            sbox[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) kw[i] = key[255-32*i -: 32];
            else begin
                t = kw[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                kw[i] = kw[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ kw[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[4*((i/4 + i%4) % 4) + i%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rnd == nr ? t[4*c+r] :
                                xt(t[4*c+r]) ^ xt(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4] ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4])
                               ^ kw[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---- stimulus helpers ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int d, input logic [255:0] key);
        logic [1919:0] wf;
        expand(key, nk_of(d), nr_of(d));
        wf = '0;
        for (int i = 0; i < 4 * (nr_of(d) + 1); i++) wf[32*i +: 32] = kw[i];
        case (d)
            0: w128 = wf[1407:0];
            1: w192 = wf[1663:0];
            default: w256 = wf;
        endcase
    endtask

    task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt);
        int n;
        n = 0;
        in_cipher[d] = ct;
        in_valid[d] = 1'b1;
        sb_q.push_back('{d, pt});
        while (!in_ready[d] && n < 100) begin
            tick();
            n++;
        end
        check_int("accept_wait", int'(in_ready[d]), 1);
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input bit rnd_ready);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'b000;
            tick();
            n++;
        end
        out_ready = 3'b111;
        check_int("drain_wait", sb_q.size(), 0);
    endtask

    // ---- monitor: accept times, latency, scoreboard ----
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst_n && in_valid[d] && in_ready[d]) acc_k[d] = cyc;
                if (out_valid[d] && !ov_prev[d]) check_int($sformatf("latency_%0d", d), cyc - acc_k[d] - 1, nr_of(d) + 1);
                if (out_valid[d] && out_ready[d]) begin
                    if (sb_q.size() == 0) check_int($sformatf("unexpected_out_%0d", d), 1, 0);
                    else begin
                        e = sb_q.pop_front();
                        check_int("sb_instance", d, e.d);
                        check($sformatf("sb_msg_%0d", d), out_msg[d], e.pt);
                    end
                end
            end
            ov_prev = out_valid;
            if (rst_n && in_valid[2] && in_ready[2]) w_hold = w256;
            assert (!(busy[2] && w256 !== w_hold)) else $error("w256 changed while a block was in flight");
        end
    end

    initial begin
        logic [127:0] pt;
        int k1;
        int n;
        int d;
        vecs[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
        in_valid = '0;
        out_ready = '1;
        for (int i = 0; i < 3; i++) in_cipher[i] = '0;
        w128 = '0;
        w192 = '0;
        w256 = '0;
        w_hold = '0;
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_int($sformatf("rst_in_ready_%0d", i), int'(in_ready[i]), 1);
            check_int($sformatf("rst_out_valid_%0d", i), int'(out_valid[i]), 0);
            check_int($sformatf("rst_busy_%0d", i), int'(busy[i]), 0);
            check_int($sformatf("rst_round_idx_%0d", i), int'(round_idx[i]), 0);
            check($sformatf("rst_out_msg_%0d", i), out_msg[i], 128'h0);
        end
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            load_key(vecs[i].d, vecs[i].key);
            check("model_ct", encrypt(vecs[i].pt, nr_of(vecs[i].d)), vecs[i].ct);
            send(vecs[i].d, vecs[i].ct, vecs[i].pt);
            drain(1'b0);
        end

        // backpressure on AES-256 (key already loaded)
        out_ready = '0;
        send(2, vecs[2].ct, vecs[2].pt);
        n = 0;
        while (!out_valid[2] && n < 50) begin
            tick();
            n++;
        end
        repeat (20) begin
            @(negedge clk);
            check("bp_msg", out_msg[2], vecs[2].pt);
            check_int("bp_valid", int'(out_valid[2]), 1);
            check_int("bp_in_ready", int'(in_ready[2]), 0);
            tick();
        end
        out_ready = '1;
        tick();
        check_int("bp_release_in_ready", int'(in_ready[2]), 1);
        check_int("bp_release_valid", int'(out_valid[2]), 0);

        // back-to-back with in_valid held high
        pt = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        send(2, vecs[2].ct, vecs[2].pt);
        k1 = acc_k[2];
        send(2, encrypt(pt, 14), pt);
        check_int("b2b_gap", acc_k[2] - k1, 17);
        drain(1'b0);

        // reset in the middle of RUN
        send(2, vecs[2].ct, vecs[2].pt);
        n = 0;
        while (round_idx[2] != 4'd5 && n < 50) begin
            tick();
            n++;
        end
        check_int("mid_round_idx", int'(round_idx[2]), 5);
        #1;
        rst_n = 1'b0;
        #1;
        check_int("mid_rst_in_ready", int'(in_ready[2]), 1);
        check_int("mid_rst_out_valid", int'(out_valid[2]), 0);
        check_int("mid_rst_busy", int'(busy[2]), 0);
        check_int("mid_rst_round_idx", int'(round_idx[2]), 0);
        check("mid_rst_out_msg", out_msg[2], 128'h0);
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        tick();
        rst_n = 1'b1;
        tick();
        check_int("post_rst_out_valid", int'(out_valid[2]), 0);
        send(2, vecs[2].ct, vecs[2].pt);
        drain(1'b0);

        // random keys, blocks, instance choice and handshake gaps
        for (int i = 0; i < 1000; i++) begin
            d = $urandom_range(0, 2);
            load_key(d, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(0, 3)) tick();
            send(d, encrypt(pt, nr_of(d)), pt);
            drain(1'b1);
        end

        check_int("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
